// File: rtl/frcounter_mod.sv
// frcounter_mod: parametrised modulo-N up/down counter with prescaler.
//
// Parameters:
//   WIDTH     counter width (1..32)
//   MODULUS   count range 0..MODULUS-1 (2..2^WIDTH)
//   SATURATE  0 = wrap at the limits, 1 = hold at the limits
//   PRESCALE  enabled cycles per count step (>= 1)
//
// Ports:
//   clk_in        clock, rising edge
//   rst_n_in      asynchronous active-low reset
//   en_in         count enable (gates the prescaler)
//   up_in         direction, 1 = up, 0 = down
//   clr_in        synchronous clear (highest priority)
//   load_in       synchronous load (clamped to MODULUS-1)
//   load_data_in  value to load
//   cmp_in        compare value
//   ovf_clr_in    clears the sticky overflow flag
//   data_out      current count
//   tc_out        terminal count for the current direction (combinational)
//   match_out     data_out == cmp_in (combinational)
//   wrap_out      one-cycle pulse after a step that hit a limit
//   ovf_out       sticky limit-event flag
module frcounter_mod #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = 0,
    parameter int              PRESCALE = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en_in,
    input  logic             up_in,
    input  logic             clr_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_data_in,
    input  logic [WIDTH-1:0] cmp_in,
    input  logic             ovf_clr_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc_out,
    output logic             match_out,
    output logic             wrap_out,
    output logic             ovf_out
);

    localparam int              PCW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0]  PC_LAST = PCW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
        MODULUS > (64'd1 << WIDTH) || PRESCALE < 1) begin : g_param_check
        $error("frcounter_mod: illegal parameter combination");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d  = cnt_q;
        pc_d   = pc_q;
        wrap_d = 1'b0;
        // set wins over clear: a limit event below overrides this
        ovf_d  = ovf_q & ~ovf_clr_in;

        if (clr_in) begin
            cnt_d = '0;
            pc_d  = '0;
        end else if (load_in) begin
            cnt_d = (load_data_in > MAX_VAL) ? MAX_VAL : load_data_in;
            pc_d  = '0;
        end else if (en_in) begin
            if (pc_q == PC_LAST) begin
                pc_d = '0;
                if (up_in) begin
                    if (cnt_q == MAX_VAL) begin
                        wrap_d = 1'b1;
                        ovf_d  = 1'b1;
                        cnt_d  = (SATURATE != 0) ? MAX_VAL : '0;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end else begin
                    if (cnt_q == '0) begin
                        wrap_d = 1'b1;
                        ovf_d  = 1'b1;
                        cnt_d  = (SATURATE != 0) ? '0 : MAX_VAL;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
            end else begin
                pc_d = pc_q + PCW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q  <= '0;
            pc_q   <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_out  = cnt_q;
    assign tc_out    = up_in ? (cnt_q == MAX_VAL) : (cnt_q == '0);
    assign match_out = (cnt_q == cmp_in);
    assign wrap_out  = wrap_q;
    assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_frcounter_mod.sv
// Directed bench for frcounter_mod: four instances share one stimulus set
// (wrap/P1, saturate/P1, wrap/P3, and a power-of-two modulus).
module tb_frcounter_mod;

    logic       clk = 1'b0;
    logic       rst_n, en, up, clr, load, ovf_clr;
    logic [3:0] ld, cmp;

    logic [3:0] w_data, s_data, p_data;
    logic [2:0] b_data;
    logic       w_tc, w_match, w_wrap, w_ovf;
    logic       s_tc, s_match, s_wrap, s_ovf;
    logic       p_tc, p_match, p_wrap, p_ovf;
    logic       b_tc, b_match, b_wrap, b_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frcounter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_wrap (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .up_in(up), .clr_in(clr),
        .load_in(load), .load_data_in(ld), .cmp_in(cmp), .ovf_clr_in(ovf_clr),
        .data_out(w_data), .tc_out(w_tc), .match_out(w_match),
        .wrap_out(w_wrap), .ovf_out(w_ovf));

    frcounter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u_sat (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .up_in(up), .clr_in(clr),
        .load_in(load), .load_data_in(ld), .cmp_in(cmp), .ovf_clr_in(ovf_clr),
        .data_out(s_data), .tc_out(s_tc), .match_out(s_match),
        .wrap_out(s_wrap), .ovf_out(s_ovf));

    frcounter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) u_ps (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .up_in(up), .clr_in(clr),
        .load_in(load), .load_data_in(ld), .cmp_in(cmp), .ovf_clr_in(ovf_clr),
        .data_out(p_data), .tc_out(p_tc), .match_out(p_match),
        .wrap_out(p_wrap), .ovf_out(p_ovf));

    frcounter_mod #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .PRESCALE(1)) u_pow (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .up_in(up), .clr_in(clr),
        .load_in(load), .load_data_in(ld[2:0]), .cmp_in(cmp[2:0]), .ovf_clr_in(ovf_clr),
        .data_out(b_data), .tc_out(b_tc), .match_out(b_match),
        .wrap_out(b_wrap), .ovf_out(b_ovf));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int e, s, p, b;
        logic [6:0] en_vec;
        logic [3:0] ps_exp [7];

        rst_n = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0;
        ovf_clr = 1'b0; ld = '0; cmp = '0;

        // reset state
        #2;
        check_eq("rst_data", w_data, 0);
        check_eq("rst_tc_down", w_tc, 1);
        check_eq("rst_match", w_match, 1);
        check_eq("rst_wrap", w_wrap, 0);
        check_eq("rst_ovf", w_ovf, 0);
        tick();
        check_eq("rst_hold_edge", w_data, 0);
        rst_n = 1'b1;
        up = 1'b1; cmp = 4'd5; en = 1'b1;
        #1;
        check_eq("rst_tc_up", w_tc, 0);
        check_eq("rst_match_cmp5", w_match, 0);

        // test 1 + match part of test 5: count up 12 steps
        for (int i = 1; i <= 12; i++) begin
            tick();
            e = i % 10;
            s = (i < 9) ? i : 9;
            p = i / 3;
            b = i % 8;
            check_eq("up_data", w_data, e);
            check_eq("up_tc", w_tc, (e == 9));
            check_eq("up_match", w_match, (e == 5));
            check_eq("up_wrap", w_wrap, (i == 10));
            check_eq("up_ovf", w_ovf, (i >= 10));
            check_eq("sat_up_data", s_data, s);
            check_eq("sat_up_wrap", s_wrap, (i >= 10));
            check_eq("ps_up_data", p_data, p);
            check_eq("pow_data", b_data, b);
            check_eq("pow_wrap", b_wrap, (i == 8));
        end

        // test 2: down from 0, wrap vs saturate
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("clr_data", w_data, 0);
        check_eq("clr_wrap", w_wrap, 0);
        check_eq("clr_sat_data", s_data, 0);
        up = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq("dn_data", w_data, 10 - k);
            check_eq("dn_wrap", w_wrap, (k == 1));
            check_eq("dn_ovf", w_ovf, 1);
            check_eq("sat_dn_data", s_data, 0);
            check_eq("sat_dn_wrap", s_wrap, 1);
            check_eq("sat_dn_tc", s_tc, 1);
        end
        en = 1'b0;
        tick();
        check_eq("dn_hold_data", w_data, 7);
        check_eq("sat_hold_wrap", s_wrap, 0);

        // test 3: prescale 3 with enable gaps
        clr = 1'b1;
        tick();
        clr = 1'b0;
        up = 1'b1;
        en_vec = 7'b1111011;   // bit 0 first
        ps_exp = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        for (int k = 0; k < 7; k++) begin
            en = en_vec[k];
            tick();
            check_eq("ps_en_data", p_data, ps_exp[k]);
        end

        // test 4: loads and clear priority
        en = 1'b0; load = 1'b1; ld = 4'd12;
        tick();
        check_eq("load12_clamp", w_data, 9);
        check_eq("load12_ps", p_data, 9);
        check_eq("load_nowrap", w_wrap, 0);
        ld = 4'd10;
        tick();
        check_eq("load10_clamp", w_data, 9);
        ld = 4'd3;
        tick();
        check_eq("load3", w_data, 3);
        clr = 1'b1; ld = 4'd5;
        tick();
        check_eq("clr_over_load", w_data, 0);
        clr = 1'b0; load = 1'b0; en = 1'b1;
        tick();
        tick();
        check_eq("ps_partial", p_data, 0);
        load = 1'b1; ld = 4'd4;
        tick();
        check_eq("ps_load4", p_data, 4);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("ps_after_load", p_data, (k == 2) ? 5 : 4);
        end

        // test 5: sticky overflow
        en = 1'b0; ovf_clr = 1'b1;
        tick();
        check_eq("ovf_clr_alone", w_ovf, 0);
        ovf_clr = 1'b0; load = 1'b1; ld = 4'd9;
        tick();
        load = 1'b0;
        check_eq("ovf_still_clear", w_ovf, 0);
        check_eq("tc_at_9", w_tc, 1);
        en = 1'b1; ovf_clr = 1'b1;
        tick();
        check_eq("ovf_set_wins_data", w_data, 0);
        check_eq("ovf_set_wins_wrap", w_wrap, 1);
        check_eq("ovf_set_wins", w_ovf, 1);
        en = 1'b0;
        tick();
        ovf_clr = 1'b0;
        check_eq("ovf_clr_after", w_ovf, 0);
        check_eq("wrap_one_cycle", w_wrap, 0);

        // test 6: asynchronous reset mid-count
        load = 1'b1; ld = 4'd6;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        repeat (5) tick();
        check_eq("pre_rst_ps_data", p_data, 7);
        check_eq("pre_rst_sat_wrap", s_wrap, 1);
        check_eq("pre_rst_sat_ovf", s_ovf, 1);
        check_eq("pre_rst_w_ovf", w_ovf, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ps_data", p_data, 0);
        check_eq("arst_sat_data", s_data, 0);
        check_eq("arst_sat_wrap", s_wrap, 0);
        check_eq("arst_sat_ovf", s_ovf, 0);
        check_eq("arst_w_ovf", w_ovf, 0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("post_rst_ps", p_data, (k == 2) ? 1 : 0);
            check_eq("post_rst_w", w_data, k + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
